// File: rtl/mux16_scanner.sv
// Sequential scanner: steps a 16:1 mux through all channels, samples y after settling, publishes 16-bit result.
// Optional MUX16_SCAN_AUTO_EN: rescans continuously from IDLE without waiting for start.
module mux16_scanner #(
  parameter int SETTLE_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        y,
  input  logic        ready_i,
  output logic        s0,
  output logic        s1,
  output logic        s2,
  output logic        s3,
  output logic        busy,
  output logic [15:0] data_o,
  output logic        valid_o
);

  // state  | meaning
  // IDLE   | selects at channel 0, waiting for a scan request
  // SETTLE | holding current channel for SETTLE_CYC cycles
  // SAMPLE | capturing y into shadow bit ch
  // DONE   | result valid, holding until consumer accepts
  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  ch, ch_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [15:0] shadow, shadow_nxt;
  logic [15:0] data_nxt;
  logic        valid_nxt;
  logic        go;

`ifdef MUX16_SCAN_AUTO_EN
  assign go = 1'b1;
`else
  assign go = start;
`endif

  assign s3 = ch[3];
  assign s2 = ch[2];
  assign s0 = ch[1];
  assign s1 = ch[0];

  always_comb begin
    state_nxt  = state;
    ch_nxt     = ch;
    cnt_nxt    = cnt;
    shadow_nxt = shadow;
    data_nxt   = data_o;
    valid_nxt  = valid_o;
    case (state)
      IDLE: begin
        ch_nxt = 4'd0;
        if (go) begin
          cnt_nxt    = 4'd0;
          shadow_nxt = 16'h0000;
          state_nxt  = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt == 4'(SETTLE_CYC - 1)) begin
          cnt_nxt   = 4'd0;
          state_nxt = SAMPLE;
        end else begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      SAMPLE: begin
        shadow_nxt[ch] = y;
        if (ch == 4'd15) begin
          // bit 15 comes straight from y; shadow is only updated at this same edge
          data_nxt  = {y, shadow[14:0]};
          valid_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          ch_nxt    = ch + 4'd1;
          state_nxt = SETTLE;
        end
      end
      DONE: begin
        if (ready_i) begin
          valid_nxt = 1'b0;
          ch_nxt    = 4'd0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ch      <= 4'd0;
      cnt     <= 4'd0;
      shadow  <= 16'h0000;
      data_o  <= 16'h0000;
      valid_o <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_nxt;
      ch      <= ch_nxt;
      cnt     <= cnt_nxt;
      shadow  <= shadow_nxt;
      data_o  <= data_nxt;
      valid_o <= valid_nxt;
      busy    <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_mux16_scanner.sv
// Directed bench for mux16_scanner with a behavioural 16:1 mux driven by the select lines.
module tb_mux16_scanner;

  logic        clk = 1'b0;
  logic        rst_n, start, y, ready_i;
  logic        s0, s1, s2, s3, busy, valid_o;
  logic [15:0] data_o;
  logic [15:0] pat;
  int          checks = 0;
  int          errors = 0;
  int          lat;

  always #5 clk = ~clk;

  assign y = pat[{s3, s2, s0, s1}];

  mux16_scanner #(.SETTLE_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .y(y), .ready_i(ready_i),
    .s0(s0), .s1(s1), .s2(s2), .s3(s3), .busy(busy),
    .data_o(data_o), .valid_o(valid_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start, then counts cycles until valid_o; checks select order on the way.
  task automatic run_scan(input logic [15:0] p, output int l);
    int sel_err;
    sel_err = 0;
    pat   = p;
    start = 1'b1;
    tick();
    start = 1'b0;
    l = 1;
    check("busy_run", {31'd0, busy}, 32'd1);
    while (!valid_o && l < 200) begin
      if (l <= 48 && {s3, s2, s0, s1} != 4'((l - 1) / 3)) sel_err++;
      if (l == 7) check("ch2_s0s1", {30'd0, s0, s1}, 32'h2);
      tick();
      l++;
    end
    check("sel_order", sel_err, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; ready_i = 1'b1; pat = 16'h0000;
    #3;
    check("rst_data",  {16'd0, data_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_sel",   {28'd0, s3, s2, s1, s0}, 32'd0);
    #9 rst_n = 1'b1;
    tick();

`ifdef MUX16_SCAN_AUTO_EN
    begin
      int per;
      pat = 16'h0F0F;
      lat = 0;
      while (!valid_o && lat < 200) begin tick(); lat++; end
      check("auto_first", {31'd0, valid_o}, 32'd1);
      check("auto_data0", {16'd0, data_o}, 32'h0F0F);
      for (int n = 0; n < 2; n++) begin
        per = 0;
        tick(); per++;
        while (!valid_o && per < 200) begin tick(); per++; end
        check("auto_period", per, 50);
        check("auto_data", {16'd0, data_o}, 32'h0F0F);
      end
    end
`else
    repeat (5) tick();
    check("idle_stays", {31'd0, busy}, 32'd0);

    // basic scan
    run_scan(16'hA5C3, lat);
    check("basic_lat",   lat, 49);
    check("basic_data",  {16'd0, data_o}, 32'hA5C3);
    tick();
    check("basic_vfall", {31'd0, valid_o}, 32'd0);
    check("basic_idle",  {31'd0, busy}, 32'd0);
    check("basic_keep",  {16'd0, data_o}, 32'hA5C3);

    // backpressure with start pulsed while waiting
    ready_i = 1'b0;
    run_scan(16'h3C96, lat);
    check("bp_lat", lat, 49);
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
      check("bp_hold", {15'd0, valid_o, data_o}, {15'd0, 1'b1, 16'h3C96});
      check("bp_sel15", {28'd0, s3, s2, s0, s1}, 32'hF);
    end
    ready_i = 1'b1;
    start   = 1'b1;
    tick();
    start = 1'b0;
    check("bp_vfall", {31'd0, valid_o}, 32'd0);
    check("bp_idle",  {31'd0, busy}, 32'd0);
    tick();
    check("hs_start_ignored", {31'd0, busy}, 32'd0);
    check("idle_sel0", {28'd0, s3, s2, s0, s1}, 32'd0);

    // abort at channel 7
    pat   = 16'h1234;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (21) tick();
    check("abort_ch7", {28'd0, s3, s2, s0, s1}, 32'h7);
    #3 rst_n = 1'b0;
    #1;
    check("abort_data",  {16'd0, data_o}, 32'd0);
    check("abort_valid", {31'd0, valid_o}, 32'd0);
    check("abort_busy",  {31'd0, busy}, 32'd0);
    check("abort_sel",   {28'd0, s3, s2, s1, s0}, 32'd0);
    tick();
    #3 rst_n = 1'b1;
    tick();
    check("abort_noval", {31'd0, valid_o}, 32'd0);
    run_scan(16'hFFFF, lat);
    check("restart_lat",  lat, 49);
    check("restart_data", {16'd0, data_o}, 32'hFFFF);
    tick();

    run_scan(16'h0001, lat);
    check("lsb_data", {16'd0, data_o}, 32'h0001);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mux16_scanner.md
MUX16_SCANNER -- requirements
Module: mux16_scanner

Interface
REQ-001 The block SHALL have one parameter: SETTLE_CYC, default 2, number of wait cycles after each select change before sampling; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request one 16-channel scan; honoured only in IDLE.
REQ-005 y  input  1  output of the downstream 16:1 mux for the currently driven select.
REQ-006 s0, s1, s2, s3  output  1 each  select lines to the 16:1 mux.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 data_o  output  16  completed scan result; bit k holds channel k.
REQ-009 valid_o  output  1  data_o holds a completed scan.
REQ-010 ready_i  input  1  consumer accepts data_o when high with valid_o high.

Function
REQ-011 Channel index ch[3:0] SHALL map to the select lines as s3=ch[3], s2=ch[2], s0=ch[1], s1=ch[0].
- Example: channel 2 drives s0=1, s1=0; channel 1 drives s0=0, s1=1.
REQ-012 The FSM SHALL have four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-013 IDLE: selects SHALL be driven to channel 0.
- start=1 -> clear ch and the settle counter, enter SETTLE.
REQ-014 SETTLE: the block SHALL hold ch on the select lines for exactly SETTLE_CYC cycles, then enter SAMPLE.
REQ-015 SAMPLE (one cycle): the block SHALL capture y into shadow bit ch.
- ch<15 -> increment ch, enter SETTLE.
- ch==15 -> load data_o from shadow (bit 15 = y in that cycle), set valid_o=1, enter DONE.
REQ-016 Latency: with start accepted in cycle T, channel k SHALL be sampled in cycle T+(k+1)(SETTLE_CYC+1), and valid_o SHALL first be high in cycle T+16(SETTLE_CYC+1)+1.
- SETTLE_CYC=2: valid_o rises at T+49.
REQ-017 DONE: valid_o and data_o SHALL be held stable while ready_i=0.
- Selects SHALL remain at channel 15.
- valid_o&ready_i -> valid_o=0 next cycle, enter IDLE.
REQ-018 start SHALL be ignored in every state except IDLE; a start asserted in the cycle of the DONE handshake SHALL be ignored.
REQ-019 data_o SHALL change only on scan completion; partial results SHALL never appear on data_o.
REQ-020 busy SHALL be a registered decode of state: 0 in IDLE, 1 otherwise.

Reset
REQ-021 rst_n=0 SHALL immediately force:
- state=IDLE, ch=0, settle counter=0, shadow=0;
- data_o=16'h0000, valid_o=0, busy=0, s0..s3=0.
REQ-022 Reset asserted mid-scan or in DONE SHALL abort the scan; no valid_o SHALL be produced for the aborted scan.
REQ-023 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Configuration
REQ-024 Macro MUX16_SCAN_AUTO_EN: when defined, the block SHALL start a scan from IDLE every cycle regardless of start.
- The DONE handshake then SHALL be followed by a new scan beginning one cycle later.
REQ-025 When MUX16_SCAN_AUTO_EN is undefined, scans SHALL start only on start per REQ-013, and the block SHALL remain in IDLE indefinitely otherwise.

Verification
REQ-026 Reset: hold rst_n=0 asynchronously mid-cycle -> data_o=0, valid_o=0, busy=0, s0..s3=0 with no clock edge required.
REQ-027 Basic scan: bench mux model i=16'hA5C3, SETTLE_CYC=2, start pulse at T, ready_i=1 -> valid_o high at T+49 for one cycle, data_o=16'hA5C3, then IDLE.
REQ-028 Select order: monitor s3,s2,s0,s1 during scan -> ch steps 0..15, each held 3 cycles; channel 2 shows s0=1, s1=0.
REQ-029 Backpressure: ready_i=0 for 10 cycles after valid_o, start pulsed during wait -> data_o and valid_o stable, start ignored; ready_i=1 -> valid_o=0 next cycle.
REQ-030 Abort: assert rst_n=0 while ch=7 -> outputs zero; restart with i=16'hFFFF -> data_o=16'hFFFF, no residue from the aborted scan.
REQ-031 MUX16_SCAN_AUTO_EN defined, start tied 0, i=16'h0F0F, ready_i=1 -> back-to-back scans, valid_o every 50 cycles, data_o=16'h0F0F.
